// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and helpers for the 4-channel mux scan sequencer.
// Channel search walks the latched enable mask in ascending order.
package mux_scan_pkg;

  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_sel_t;

  // Lowest enabled channel strictly above cur.
  function automatic ch_sel_t next_ch(input logic [NUM_CH-1:0] mask,
                                      input logic [SEL_W-1:0]  cur);
    ch_sel_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        r.found = 1'b1;
        r.ch    = SEL_W'(i);
      end
    end
    return r;
  endfunction

  function automatic ch_sel_t first_ch(input logic [NUM_CH-1:0] mask);
    ch_sel_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.ch    = SEL_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Request/response bundle between the scan sequencer, its client and the mux.
// slave is the sequencer side; master is the client/mux side.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 4
);

  logic                           start;
  logic [DWELL_W-1:0]             dwell;
  logic [NUM_CH-1:0]              mask;
  logic                           mux_out;
  logic [mux_scan_pkg::SEL_W-1:0] sel;
  logic                           busy;
  logic                           done;
  logic [NUM_CH-1:0]              sample;

  modport slave (
    input  start, dwell, mask, mux_out,
    output sel, busy, done, sample
  );

  modport master (
    output start, dwell, mask, mux_out,
    input  sel, busy, done, sample
  );

endinterface

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Load/decrement settle counter; saturates at zero so a maximal load never wraps.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled mux channels in ascending order, holding each select for
// the latched settle time, and returns the captured bits as one word with done.
module mux_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  import mux_scan_pkg::*;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_CH-1:0]  sample_q;
  logic [NUM_CH-1:0]  scratch;
  logic [NUM_CH-1:0]  scratch_nxt;
  logic [NUM_CH-1:0]  mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] start_val;
  logic               accept;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [DWELL_W-1:0] cnt_val;
  ch_sel_t            first_c;
  ch_sel_t            next_c;

  // Counter holds D-1 so that SETTLE lasts D cycles; dwell 0 behaves as 1.
  assign start_val = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign accept    = (state == IDLE) && bus.start;
  assign first_c   = first_ch(bus.mask);
  assign next_c    = next_ch(mask_q, sel_q);

  assign cnt_load  = (accept && first_c.found) || (state == CAPTURE && next_c.found);
  assign cnt_val   = (state == IDLE) ? start_val : dwell_q;
  assign cnt_dec   = (state == SETTLE);

  always_comb begin
    scratch_nxt        = scratch;
    scratch_nxt[sel_q] = bus.mux_out;
  end

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Scan parameters are frozen at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      mask_q  <= bus.mask;
      dwell_q <= start_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
      scratch  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            scratch <= '0;
            if (first_c.found) begin
              sel_q  <= first_c.ch;
              busy_q <= 1'b1;
              state  <= SETTLE;
            end else begin
              sample_q <= '0;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt_zero) state <= CAPTURE;
        end
        CAPTURE: begin
          scratch <= scratch_nxt;
          if (next_c.found) begin
            sel_q <= next_c.ch;
            state <= SETTLE;
          end else begin
            sample_q <= scratch_nxt;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: the bench plays the 4:1 mux and compares
// each done against a cycle-level model of latency, select runs and sample.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] mux_in;
  int         cyc;
  int         checks;
  int         errors;

  typedef struct {
    int         c0;
    int         lat;
    int         busy_n;
    int         hold;
    int         nruns;
    int         ch[4];
    logic [3:0] samp;
  } exp_t;

  exp_t sb[$];
  int   run_ch[$];
  int   run_len[$];
  int   busy_cnt;

  mux_scan_ctrl_if #(.DWELL_W(8), .NUM_CH(4)) bus ();

  mux_scan_ctrl #(.DWELL_W(8), .NUM_CH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.mux_out = mux_in[bus.sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: N enabled channels, each selected for D+1 cycles, done one cycle later.
  task automatic push_exp(input logic [3:0] m, input logic [7:0] dw, input logic [3:0] mi);
    exp_t e;
    int d;
    d = (dw == 0) ? 1 : int'(dw);
    e.c0 = cyc;
    e.nruns = 0;
    for (int c = 0; c < 4; c++) begin
      e.ch[c] = 0;
      if (m[c]) begin
        e.ch[e.nruns] = c;
        e.nruns++;
      end
    end
    e.hold   = d + 1;
    e.busy_n = e.nruns * (d + 1);
    e.lat    = e.busy_n + 1;
    e.samp   = mi & m;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] m, input logic [7:0] dw, input logic [3:0] mi);
    mux_in    = mi;
    bus.mask  = m;
    bus.dwell = dw;
    bus.start = 1'b1;
    push_exp(m, dw, mi);
  endtask

  task automatic wait_done(input bit noise);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mask  = 4'($urandom);
        bus.dwell = 8'($urandom_range(0, 6));
      end else begin
        bus.start = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", n);
    end
  endtask

  task automatic scan(input logic [3:0] m, input logic [7:0] dw, input logic [3:0] mi, input bit noise);
    @(negedge clk);
    issue(m, dw, mi);
    wait_done(noise);
    bus.start = 1'b0;
  endtask

  // Monitor: accumulates select runs while busy and scores each done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_ch.delete();
        run_len.delete();
        busy_cnt = 0;
      end else begin
        if (bus.busy) begin
          busy_cnt++;
          if (run_ch.size() > 0 && run_ch[$] == int'(bus.sel)) run_len[$] = run_len[$] + 1;
          else begin
            run_ch.push_back(int'(bus.sel));
            run_len.push_back(1);
          end
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d with no scan pending", cyc);
          end else begin
            e = sb.pop_front();
            check("done_latency", cyc - e.c0, e.lat);
            check("sample", bus.sample, e.samp);
            check("busy_cycles", busy_cnt, e.busy_n);
            check("sel_runs", run_ch.size(), e.nruns);
            for (int i = 0; i < e.nruns && i < run_ch.size(); i++) begin
              check("sel_order", run_ch[i], e.ch[i]);
              check("sel_hold", run_len[i], e.hold);
            end
          end
          run_ch.delete();
          run_len.delete();
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int done_seen;
    int c0;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    busy_cnt  = 0;
    mux_in    = 4'b0000;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd1;
    repeat (3) @(negedge clk);
    check("rst_sel", bus.sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sample", bus.sample, 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    scan(4'b1111, 8'd2, 4'b1010, 1'b0);
    scan(4'b0101, 8'd0, 4'b1111, 1'b0);
    scan(4'b0000, 8'd5, 4'b1111, 1'b0);
    scan(4'b1011, 8'd3, 4'b1110, 1'b1);

    // Start held through DONE is ignored; the following IDLE cycle accepts it.
    bus.start = 1'b1;
    bus.mask  = 4'b0110;
    @(negedge clk);
    issue(4'b0110, 8'd1, 4'b0111);
    wait_done(1'b0);
    bus.start = 1'b0;

    // Abort in the second channel's settle window.
    @(negedge clk);
    issue(4'b1111, 8'd4, 4'b1111);
    c0 = cyc;
    while (cyc - c0 < 7) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sel", bus.sel, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_sample", bus.sample, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    scan(4'b1111, 8'd255, 4'b0110, 1'b0);

    for (int k = 0; k < 20; k++) begin
      scan(4'($urandom), 8'($urandom_range(0, 12)), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 4-to-1 multiplexer. It drives the mux `sel` lines through the enabled channels in ascending order and holds each selection for a programmable settle time. It samples the single-bit mux output once per channel and presents the four captured bits as one word with a one-cycle `done` pulse. It turns the combinational mux into a scanned 4-channel input port for downstream logic.

## Interface
- `DWELL_W`, default 8: width of the settle-count input.
- `NUM_CH`, default 4: channel count. Fixed at 4 to match the mux width; other values are not supported.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset. Synchronous, active-low.
- `start`  input  1  scan request. Sampled only in IDLE.
- `dwell`  input  DWELL_W  settle cycles per channel. Latched at start; value 0 is treated as 1.
- `mask`  input  4  channel enable, bit n enables channel n. Latched at start.
- `mux_out`  input  1  output of the downstream 4-to-1 mux.
- `sel`  output  2  select lines to the mux.
- `busy`  output  1  high while a scan is in progress (SETTLE or CAPTURE).
- `done`  output  1  one-cycle pulse marking the end of a scan.
- `sample`  output  4  captured word. Bit n holds channel n. Masked bits are 0.

## Operation
- States:
  - IDLE: waits for `start`. On `start`=1, latch `dwell` and `mask`, then:
    - mask = 0: go to DONE.
    - otherwise: set sel = lowest enabled channel, load the counter with max(dwell,1)-1, go to SETTLE.
  - SETTLE: decrement the counter each cycle. When the counter reaches 0, go to CAPTURE on the next edge.
  - CAPTURE: on the exit edge, write `mux_out` into scratch bit `sel`. Then:
    - if a higher enabled channel exists: set sel to it, reload the counter, go to SETTLE.
    - otherwise: copy scratch to `sample` and go to DONE.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- The scratch register clears to 0 on the start-accept edge, so masked channels read 0.
- `start` is ignored in SETTLE, CAPTURE and DONE. It is not queued.
- A change on `dwell` or `mask` during a scan has no effect until the next accepted start.
- `sel` holds its last value in IDLE and DONE.
- `sample` holds its value until the next scan completes.
- Reset: `rst_n`=0 at a clock edge forces IDLE and sets sel=0, busy=0, done=0, sample=0, scratch=0 and counter=0. A scan in progress is aborted and no `done` is issued. Reset takes priority over `start` on the same edge.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Let D = max(dwell,1) and N = popcount(mask).
- Start is accepted at edge 0.
- busy=1 from cycle 1 through cycle N·(D+1).
- done=1 in cycle N·(D+1)+1; `sample` is valid from that cycle onward.
- mask=0: done=1 in cycle 1, busy stays 0, sample=0.
- `mux_out` is sampled in the last CAPTURE cycle per channel. `sel` has been stable for D+1 cycles at that point.
- Back-to-back scans: the earliest next accept is the IDLE cycle after DONE, which is the minimum gap.
- Maximum dwell: D = 2^DWELL_W − 1. The counter must not wrap.

## Structure
- Shared package `mux_scan_pkg` holds:
  - state enum (IDLE, SETTLE, CAPTURE, DONE)
  - SEL_W = 2, NUM_CH = 4
  - function `next_ch(mask, cur)`: returns the next higher enabled channel plus a found flag.
- One sub-module, `dwell_counter`: load/decrement down-counter with a zero flag, parameterised by DWELL_W.
- The FSM, scratch register and output registers live in the top.

## Test plan
- Full scan, mask=1111, dwell=2, mux fed by i=1010:
  - sel steps 0,1,2,3, each held 3 cycles.
  - done is high in cycle 13.
  - sample=1010.
- Sparse mask, mask=0101, dwell=0, i=1111:
  - sel steps 0 then 2.
  - done is high in cycle 5.
  - sample=0101.
- Empty mask, mask=0000:
  - done is high in cycle 1, busy never rises, sample=0000.
- Ignored inputs: pulse `start` during busy and change mask mid-scan.
  - No restart occurs; the result matches the original mask.
  - A second scan is accepted only after DONE.
- Reset mid-scan: drop rst_n in the second SETTLE of a mask=1111, dwell=4 scan.
  - Next cycle: sel=0, busy=0, sample=0.
  - done never pulses.
- Dwell boundary: dwell=255.
  - Each channel is held 256 cycles.
  - The counter does not wrap; done is high at cycle 4·256+1 = 1025.
